// File: rtl/clb_cfg_sequencer.sv
// Configuration sequencer for the CLB array: walks the CLBs in index order, routes the
// fabric bitstream to the selected CLB, polices tlast framing and stalls, then releases run.
module clb_cfg_sequencer #(
  parameter int NUM_CLBS             = 4,
  parameter int BITSTREAM_DATA_WIDTH = 1,
  parameter int TIMEOUT_CYCLES       = 1024,
  parameter int IDX_W                = (NUM_CLBS > 1) ? $clog2(NUM_CLBS) : 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic                            s_tvalid,
  input  logic [BITSTREAM_DATA_WIDTH-1:0] s_tdata,
  input  logic                            s_tlast,
  output logic                            s_tready,
  output logic [NUM_CLBS-1:0]             clb_cfg,
  output logic [NUM_CLBS-1:0]             clb_tvalid,
  output logic [BITSTREAM_DATA_WIDTH-1:0] clb_tdata,
  output logic                            clb_tlast,
  input  logic [NUM_CLBS-1:0]             clb_tready,
  input  logic [NUM_CLBS-1:0]             clb_cfg_ready,
  input  logic                            run_req,
  output logic                            clb_run,
  output logic                            busy,
  output logic                            done,
  output logic [1:0]                      error,
  output logic [IDX_W-1:0]                clb_idx
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0]    CNT_MAX  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(NUM_CLBS - 1);
  localparam logic [NUM_CLBS-1:0] ONE_HOT0 = NUM_CLBS'(1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SELECT = 3'd1,
    ST_STREAM = 3'd2,
    ST_DONE   = 3'd3,
    ST_ERROR  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] clb_idx_q, clb_idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             beat_seen_q, beat_seen_d;
  logic             tlast_seen_q, tlast_seen_d;
  logic [1:0]       error_q, error_d;

  logic                in_stream_s;
  logic                is_last_s;
  logic                xfer_s;
  logic                beat_eff_s;
  logic                tlast_eff_s;
  logic                complete_s;
  logic                early_tlast_s;
  logic                timeout_s;
  logic [NUM_CLBS-1:0] sel_oh_s;

  // Datapath qualifiers; rst_n gating keeps a beat from being taken in the reset cycle
  always_comb begin
    sel_oh_s      = ONE_HOT0 << clb_idx_q;
    in_stream_s   = rst_n && (state_q == ST_STREAM);
    is_last_s     = (clb_idx_q == IDX_LAST);
    xfer_s        = in_stream_s && s_tvalid && clb_tready[clb_idx_q];
    beat_eff_s    = beat_seen_q || xfer_s;
    tlast_eff_s   = tlast_seen_q || (xfer_s && s_tlast && is_last_s);
    complete_s    = in_stream_s && clb_cfg_ready[clb_idx_q] && beat_eff_s;
    early_tlast_s = xfer_s && s_tlast && !is_last_s;
    timeout_s     = in_stream_s && !xfer_s && (cnt_q == CNT_MAX);
  end

  // Next-state logic; completion outranks early tlast, which outranks timeout
  always_comb begin
    state_d      = state_q;
    clb_idx_d    = clb_idx_q;
    cnt_d        = cnt_q;
    beat_seen_d  = beat_seen_q;
    tlast_seen_d = tlast_seen_q;
    error_d      = error_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          state_d      = ST_SELECT;
          clb_idx_d    = '0;
          error_d      = 2'd0;
          tlast_seen_d = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      ST_SELECT: begin
        beat_seen_d = 1'b0;
        cnt_d       = '0;
        state_d     = ST_STREAM;
      end
      ST_STREAM: begin
        if (xfer_s) begin
          beat_seen_d = 1'b1;
          cnt_d       = '0;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          cnt_d = cnt_q;
        end
        tlast_seen_d = tlast_eff_s;
        if (complete_s) begin
          if (!is_last_s) begin
            clb_idx_d = clb_idx_q + IDX_W'(1);
            state_d   = ST_SELECT;
          end else if (tlast_eff_s) begin
            state_d = ST_DONE;
          end else begin
            error_d = 2'd3;
            state_d = ST_ERROR;
          end
        end else if (early_tlast_s) begin
          error_d = 2'd1;
          state_d = ST_ERROR;
        end else if (timeout_s) begin
          error_d = 2'd2;
          state_d = ST_ERROR;
        end else begin
          state_d = ST_STREAM;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and context registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      clb_idx_q    <= '0;
      cnt_q        <= '0;
      beat_seen_q  <= 1'b0;
      tlast_seen_q <= 1'b0;
      error_q      <= 2'd0;
    end else begin
      state_q      <= state_d;
      clb_idx_q    <= clb_idx_d;
      cnt_q        <= cnt_d;
      beat_seen_q  <= beat_seen_d;
      tlast_seen_q <= tlast_seen_d;
      error_q      <= error_d;
    end
  end

  // Output decode: zero-latency stream routing to the selected CLB only
  always_comb begin
    s_tready   = in_stream_s && clb_tready[clb_idx_q];
    clb_tvalid = (in_stream_s && s_tvalid) ? sel_oh_s : '0;
    clb_cfg    = (rst_n && (state_q == ST_SELECT)) ? sel_oh_s : '0;
    clb_tdata  = s_tdata;
    clb_tlast  = s_tlast;
    clb_run    = rst_n && run_req && (state_q == ST_DONE);
    busy       = (state_q == ST_SELECT) || (state_q == ST_STREAM);
    done       = (state_q == ST_DONE);
    error      = error_q;
    clb_idx    = clb_idx_q;
  end

endmodule

// File: tb/tb_clb_cfg_sequencer.sv
// Directed bench for clb_cfg_sequencer with a behavioural CLB model and a beat scoreboard.
module tb_clb_cfg_sequencer;

  localparam int N    = 4;
  localparam int DW   = 8;
  localparam int TMO  = 32;
  localparam int BPC  = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          s_tvalid;
  logic [DW-1:0] s_tdata;
  logic          s_tlast;
  logic          s_tready;
  logic [N-1:0]  clb_cfg;
  logic [N-1:0]  clb_tvalid;
  logic [DW-1:0] clb_tdata;
  logic          clb_tlast;
  logic [N-1:0]  clb_tready;
  logic [N-1:0]  clb_cfg_ready;
  logic          run_req;
  logic          clb_run;
  logic          busy;
  logic          done;
  logic [1:0]    error;
  logic [1:0]    clb_idx;

  int vectors    = 0;
  int miscompares = 0;

  typedef struct {
    int            idx;
    logic [DW-1:0] data;
  } exp_t;
  exp_t sb[$];
  int   cfg_seen[$];

  // CLB model state
  int unsigned bcnt[N];
  int unsigned dly[N];
  bit [N-1:0]  rdy   = '0;
  bit [N-1:0]  stale = '0;
  bit [N-1:0]  block = '0;

  always #5 clk = ~clk;

  clb_cfg_sequencer #(
    .NUM_CLBS(N), .BITSTREAM_DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .s_tvalid(s_tvalid), .s_tdata(s_tdata), .s_tlast(s_tlast), .s_tready(s_tready),
    .clb_cfg(clb_cfg), .clb_tvalid(clb_tvalid), .clb_tdata(clb_tdata), .clb_tlast(clb_tlast),
    .clb_tready(clb_tready), .clb_cfg_ready(clb_cfg_ready),
    .run_req(run_req), .clb_run(clb_run), .busy(busy), .done(done),
    .error(error), .clb_idx(clb_idx)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // CLB accepts BPC beats, then raises cfg_ready two cycles after the last one
  always_comb begin
    for (int i = 0; i < N; i++) begin
      clb_tready[i]    = !block[i] && (bcnt[i] < BPC);
      clb_cfg_ready[i] = rdy[i] | stale[i];
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (clb_cfg[i]) begin
        bcnt[i] <= 0;
        dly[i]  <= 0;
        rdy[i]  <= 1'b0;
      end else begin
        if (clb_tvalid[i] && s_tready) bcnt[i] <= bcnt[i] + 1;
        if (bcnt[i] >= BPC && !rdy[i]) begin
          if (dly[i] == 1) rdy[i] <= 1'b1;
          else dly[i] <= dly[i] + 1;
        end
      end
    end
  end

  // Monitor: pop the scoreboard on each transfer and log cfg pulses
  always @(negedge clk) begin
    int   oi;
    exp_t e;
    if (s_tvalid && s_tready) begin
      oi = -1;
      for (int i = 0; i < N; i++) if (clb_tvalid[i]) oi = i;
      if (sb.size() == 0) begin
        chk("sb_unexpected_beat", 32'(oi), 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        chk("sb_idx", 32'(oi), 32'(e.idx));
        chk("sb_data", 32'(clb_tdata), 32'(e.data));
        chk("sb_tvalid_onehot", 32'(clb_tvalid), 32'(1) << e.idx);
      end
    end
    if (clb_cfg != '0) begin
      oi = -1;
      for (int i = 0; i < N; i++) if (clb_cfg[i]) oi = i;
      cfg_seen.push_back(oi);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_beat(input int idx, input logic [DW-1:0] d, input logic last);
    int n;
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tlast  = last;
    sb.push_back('{idx, d});
    n = 0;
    forever begin
      @(negedge clk);
      if (s_tready) break;
      n++;
      if (n > 200) begin
        chk("beat_accept_timeout", 32'(n), 32'(0));
        break;
      end
    end
    tick();
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic full_pass(input logic with_tlast, input logic [DW-1:0] seed);
    for (int b = 0; b < N * BPC; b++) begin
      send_beat(b / BPC, seed + DW'(b), with_tlast && (b == N * BPC - 1));
      chk("run_gated_in_config", 32'(clb_run), 32'(0));
    end
  endtask

  task automatic wait_end();
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (done || error != 2'd0) break;
      n++;
      if (n > 200) begin
        chk("wait_end_timeout", 32'(n), 32'(0));
        break;
      end
    end
  endtask

  task automatic chk_cfg_order();
    chk("cfg_pulse_count", 32'(cfg_seen.size()), 32'(N));
    for (int i = 0; i < N && i < cfg_seen.size(); i++)
      chk("cfg_pulse_order", 32'(cfg_seen[i]), 32'(i));
  endtask

  initial begin
    int n;
    rst_n = 1'b0; start = 1'b0; s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0; run_req = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_error", 32'(error), 32'(0));
    chk("rst_idx", 32'(clb_idx), 32'(0));
    chk("rst_tready", 32'(s_tready), 32'(0));
    chk("rst_cfg", 32'(clb_cfg), 32'(0));
    chk("rst_run", 32'(clb_run), 32'(0));
    tick();
    rst_n = 1'b1;
    tick();

    // 1: clean pass with tlast on beat 12
    run_req = 1'b1;
    cfg_seen.delete();
    do_start();
    full_pass(1'b1, 8'h10);
    wait_end();
    chk("t1_done", 32'(done), 32'(1));
    chk("t1_error", 32'(error), 32'(0));
    chk("t1_run", 32'(clb_run), 32'(1));
    chk("t1_busy", 32'(busy), 32'(0));
    chk_cfg_order();
    s_tvalid = 1'b1;
    @(negedge clk);
    chk("t1_done_stalls_upstream", 32'(s_tready), 32'(0));
    tick();
    s_tvalid = 1'b0;

    // 2: early tlast on beat 6
    do_start();
    for (int b = 0; b < 6; b++) send_beat(b / BPC, 8'h40 + 8'(b), b == 5);
    s_tvalid = 1'b1;
    @(negedge clk);
    chk("t2_error", 32'(error), 32'(1));
    chk("t2_tready", 32'(s_tready), 32'(0));
    chk("t2_done", 32'(done), 32'(0));
    chk("t2_run", 32'(clb_run), 32'(0));
    tick();
    s_tvalid = 1'b0;

    // 3: CLB 2 never ready -> timeout
    block[2] = 1'b1;
    do_start();
    for (int b = 0; b < 6; b++) send_beat(b / BPC, 8'h60 + 8'(b), 1'b0);
    s_tvalid = 1'b1;
    s_tdata  = 8'h77;
    n = 0;
    forever begin
      @(negedge clk);
      if (clb_cfg[2]) break;
      n++;
      if (n > 200) begin chk("t3_select_timeout", 32'(n), 32'(0)); break; end
    end
    n = 0;
    forever begin
      @(negedge clk);
      n++;
      if (error != 2'd0 || n > 200) break;
    end
    chk("t3_timeout_cycles", 32'(n), 32'(TMO + 1));
    chk("t3_error", 32'(error), 32'(2));
    chk("t3_idx", 32'(clb_idx), 32'(2));
    chk("t3_tready", 32'(s_tready), 32'(0));
    tick();
    s_tvalid = 1'b0;
    block[2] = 1'b0;

    // 4: stale cfg_ready on CLB 0 before any beat
    stale[0] = 1'b1;
    do_start();
    repeat (5) tick();
    chk("t4_no_advance_idx", 32'(clb_idx), 32'(0));
    chk("t4_busy", 32'(busy), 32'(1));
    send_beat(0, 8'h80, 1'b0);
    chk("t4_advance_idx", 32'(clb_idx), 32'(1));
    stale[0] = 1'b0;
    for (int b = BPC; b < N * BPC; b++) send_beat(b / BPC, 8'h80 + 8'(b), b == N * BPC - 1);
    wait_end();
    chk("t4_done", 32'(done), 32'(1));
    chk("t4_error", 32'(error), 32'(0));

    // 5: missing tlast, then a clean restart
    do_start();
    full_pass(1'b0, 8'hA0);
    wait_end();
    chk("t5_error", 32'(error), 32'(3));
    chk("t5_done", 32'(done), 32'(0));
    do_start();
    chk("t5_error_cleared", 32'(error), 32'(0));
    full_pass(1'b1, 8'hB0);
    wait_end();
    chk("t5_retry_done", 32'(done), 32'(1));
    chk("t5_retry_error", 32'(error), 32'(0));

    // 6: reset mid-stream on CLB 1, then resume from CLB 0
    do_start();
    for (int b = 0; b < 4; b++) send_beat(b / BPC, 8'hC0 + 8'(b), 1'b0);
    chk("t6_run_gated", 32'(clb_run), 32'(0));
    chk("t6_busy", 32'(busy), 32'(1));
    chk("t6_idx", 32'(clb_idx), 32'(1));
    s_tvalid = 1'b1;
    s_tdata  = 8'hEE;
    rst_n    = 1'b0;
    @(negedge clk);
    chk("t6_rst_tready", 32'(s_tready), 32'(0));
    chk("t6_rst_tvalid", 32'(clb_tvalid), 32'(0));
    tick();
    rst_n    = 1'b1;
    s_tvalid = 1'b0;
    @(negedge clk);
    chk("t6_idle_busy", 32'(busy), 32'(0));
    chk("t6_idle_idx", 32'(clb_idx), 32'(0));
    chk("t6_idle_error", 32'(error), 32'(0));
    chk("t6_idle_done", 32'(done), 32'(0));
    chk("t6_idle_run", 32'(clb_run), 32'(0));
    chk("t6_idle_cfg", 32'(clb_cfg), 32'(0));
    tick();
    cfg_seen.delete();
    do_start();
    full_pass(1'b1, 8'hD0);
    wait_end();
    chk("t6_done", 32'(done), 32'(1));
    chk("t6_run", 32'(clb_run), 32'(1));
    chk_cfg_order();

    chk("sb_drained", 32'(sb.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
